// File: rtl/execute_unit.sv
// Execute stage of the RV32I core: operand select, ALU, branch/jump resolution,
// load extraction and store lane placement. Writeback and jump results are registered.
`ifndef MEMORY_WIDTH
`define MEMORY_WIDTH 32
`endif

module execute_unit #(
  parameter int MEMORY_WIDTH = `MEMORY_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rv32_r_add,
  input  logic                    rv32_r_sub,
  input  logic                    rv32_r_sll,
  input  logic                    rv32_r_slt,
  input  logic                    rv32_r_sltu,
  input  logic                    rv32_r_xor,
  input  logic                    rv32_r_or,
  input  logic                    rv32_r_and,
  input  logic                    rv32_r_srl,
  input  logic                    rv32_r_sra,
  input  logic                    rv32_i_addi,
  input  logic                    rv32_i_slti,
  input  logic                    rv32_i_sltiu,
  input  logic                    rv32_i_xori,
  input  logic                    rv32_i_ori,
  input  logic                    rv32_i_andi,
  input  logic                    rv32_i_slli,
  input  logic                    rv32_i_srli,
  input  logic                    rv32_i_srai,
  input  logic                    rv32_b_beq,
  input  logic                    rv32_b_bne,
  input  logic                    rv32_b_blt,
  input  logic                    rv32_b_bge,
  input  logic                    rv32_b_bltu,
  input  logic                    rv32_b_bgeu,
  input  logic                    rv32_j_jal,
  input  logic                    rv32_i_jalr,
  input  logic                    rv32_u_lui,
  input  logic                    rv32_u_auipc,
  input  logic                    rv32_s_sb,
  input  logic                    rv32_s_sh,
  input  logic                    rv32_s_sw,
  input  logic                    rv32_i_lb,
  input  logic                    rv32_i_lh,
  input  logic                    rv32_i_lw,
  input  logic                    rv32_i_lbu,
  input  logic                    rv32_i_lhu,
  input  logic                    rv32_i_ecall,
  input  logic                    rv32_i_ebreak,
  input  logic                    rv32_i_csrrw,
  input  logic                    rv32_i_csrrs,
  input  logic                    rv32_i_csrrc,
  input  logic                    rv32_i_csrrwi,
  input  logic                    rv32_i_csrrsi,
  input  logic                    rv32_i_csrrci,
  input  logic                    rv32_i_fence,
  input  logic                    rv32_i_fence_i,
  input  logic                    rv32_r,
  input  logic                    rv32_i,
  input  logic                    rv32_s,
  input  logic                    rv32_u,
  input  logic                    rv32_j,
  input  logic                    rv32_b,
  input  logic [31:0]             rv32_i_imm,
  input  logic [31:0]             rv32_s_imm,
  input  logic [31:0]             rv32_u_imm,
  input  logic [31:0]             rv32_uj_imm,
  input  logic [31:0]             rv32_b_imm,
  input  logic [31:0]             rv32_rd_data,
  input  logic [31:0]             rv32_rs1_data,
  input  logic [31:0]             rv32_rs2_data,
  input  logic [31:0]             pc_read_data,
  input  logic [MEMORY_WIDTH-1:0] memory_read_data,
  output logic [31:0]             rd_write_data,
  output logic                    rd_write_enable,
  output logic                    jump_enable,
  output logic [31:0]             jump_address,
  output logic [31:0]             memory_address,
  output logic                    memory_read_enable,
  output logic                    memory_write_enable,
  output logic [MEMORY_WIDTH-1:0] memory_write_data,
  output logic [3:0]              memory_write_mask
);

  typedef enum logic [5:0] {
    OP_NOP, OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_OR, OP_AND,
    OP_SRL, OP_SRA, OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_SB, OP_SH, OP_SW,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SYS
  } op_e;

  op_e         op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [4:0]  shamt;
  logic [31:0] alu_result;
  logic        branch_taken;
  logic        is_load;
  logic        is_store;
  logic [31:0] read_word;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_result;
  logic [31:0] store_word;
  logic        wb_enable;
  logic [31:0] wb_data;
  logic        jump_taken;
  logic [31:0] jump_target;
  logic        unused_inputs;

  assign unused_inputs = ^rv32_rd_data;

  // Strobes should be one-hot; the chain order gives port-list priority if not.
  always_comb begin
    op = OP_NOP;
    if      (rv32_r_add)     op = OP_ADD;
    else if (rv32_r_sub)     op = OP_SUB;
    else if (rv32_r_sll)     op = OP_SLL;
    else if (rv32_r_slt)     op = OP_SLT;
    else if (rv32_r_sltu)    op = OP_SLTU;
    else if (rv32_r_xor)     op = OP_XOR;
    else if (rv32_r_or)      op = OP_OR;
    else if (rv32_r_and)     op = OP_AND;
    else if (rv32_r_srl)     op = OP_SRL;
    else if (rv32_r_sra)     op = OP_SRA;
    else if (rv32_i_addi)    op = OP_ADD;
    else if (rv32_i_slti)    op = OP_SLT;
    else if (rv32_i_sltiu)   op = OP_SLTU;
    else if (rv32_i_xori)    op = OP_XOR;
    else if (rv32_i_ori)     op = OP_OR;
    else if (rv32_i_andi)    op = OP_AND;
    else if (rv32_i_slli)    op = OP_SLL;
    else if (rv32_i_srli)    op = OP_SRL;
    else if (rv32_i_srai)    op = OP_SRA;
    else if (rv32_b_beq)     op = OP_BEQ;
    else if (rv32_b_bne)     op = OP_BNE;
    else if (rv32_b_blt)     op = OP_BLT;
    else if (rv32_b_bge)     op = OP_BGE;
    else if (rv32_b_bltu)    op = OP_BLTU;
    else if (rv32_b_bgeu)    op = OP_BGEU;
    else if (rv32_j_jal)     op = OP_JAL;
    else if (rv32_i_jalr)    op = OP_JALR;
    else if (rv32_u_lui)     op = OP_LUI;
    else if (rv32_u_auipc)   op = OP_AUIPC;
    else if (rv32_s_sb)      op = OP_SB;
    else if (rv32_s_sh)      op = OP_SH;
    else if (rv32_s_sw)      op = OP_SW;
    else if (rv32_i_lb)      op = OP_LB;
    else if (rv32_i_lh)      op = OP_LH;
    else if (rv32_i_lw)      op = OP_LW;
    else if (rv32_i_lbu)     op = OP_LBU;
    else if (rv32_i_lhu)     op = OP_LHU;
    else if (rv32_i_ecall | rv32_i_ebreak | rv32_i_csrrw | rv32_i_csrrs |
             rv32_i_csrrc | rv32_i_csrrwi | rv32_i_csrrsi | rv32_i_csrrci |
             rv32_i_fence | rv32_i_fence_i)
      op = OP_SYS;
  end

  always_comb begin
    operand_a = rv32_rs1_data;
    if (op == OP_LUI)        operand_a = '0;
    else if (op == OP_AUIPC) operand_a = pc_read_data;

    operand_b = '0;
    if (rv32_r || rv32_b) operand_b = rv32_rs2_data;
    else if (rv32_i)      operand_b = rv32_i_imm;
    else if (rv32_s)      operand_b = rv32_s_imm;
    else if (rv32_u)      operand_b = rv32_u_imm;
    else if (rv32_j)      operand_b = rv32_uj_imm;
  end

  assign shamt = operand_b[4:0];

  // LUI and AUIPC reuse the adder: operand A is forced to 0 or pc for them.
  always_comb begin
    alu_result = '0;
    case (op)
      OP_ADD, OP_LUI, OP_AUIPC: alu_result = operand_a + operand_b;
      OP_SUB:  alu_result = operand_a - operand_b;
      OP_SLL:  alu_result = operand_a << shamt;
      OP_SLT:  alu_result = {31'b0, $signed(operand_a) < $signed(operand_b)};
      OP_SLTU: alu_result = {31'b0, operand_a < operand_b};
      OP_XOR:  alu_result = operand_a ^ operand_b;
      OP_OR:   alu_result = operand_a | operand_b;
      OP_AND:  alu_result = operand_a & operand_b;
      OP_SRL:  alu_result = operand_a >> shamt;
      OP_SRA:  alu_result = $signed(operand_a) >>> shamt;
      default: alu_result = '0;
    endcase
  end

  always_comb begin
    branch_taken = 1'b0;
    case (op)
      OP_BEQ:  branch_taken = rv32_rs1_data == rv32_rs2_data;
      OP_BNE:  branch_taken = rv32_rs1_data != rv32_rs2_data;
      OP_BLT:  branch_taken = $signed(rv32_rs1_data) < $signed(rv32_rs2_data);
      OP_BGE:  branch_taken = $signed(rv32_rs1_data) >= $signed(rv32_rs2_data);
      OP_BLTU: branch_taken = rv32_rs1_data < rv32_rs2_data;
      OP_BGEU: branch_taken = rv32_rs1_data >= rv32_rs2_data;
      default: branch_taken = 1'b0;
    endcase
  end

  assign is_load  = (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
                    (op == OP_LBU) || (op == OP_LHU);
  assign is_store = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);

  assign memory_address      = rv32_rs1_data + (is_store ? rv32_s_imm : rv32_i_imm);
  assign memory_read_enable  = is_load;
  assign memory_write_enable = is_store;

  assign read_word = memory_read_data[31:0];
  assign load_byte = 8'(read_word >> {memory_address[1:0], 3'b000});
  assign load_half = memory_address[1] ? read_word[31:16] : read_word[15:0];

  always_comb begin
    load_result = '0;
    case (op)
      OP_LB:   load_result = {{24{load_byte[7]}}, load_byte};
      OP_LH:   load_result = {{16{load_half[15]}}, load_half};
      OP_LW:   load_result = read_word;
      OP_LBU:  load_result = {24'b0, load_byte};
      OP_LHU:  load_result = {16'b0, load_half};
      default: load_result = '0;
    endcase
  end

  // Halfword and word stores ignore the misaligned low address bits.
  always_comb begin
    store_word        = '0;
    memory_write_mask = 4'b0000;
    case (op)
      OP_SB: begin
        store_word        = {24'b0, rv32_rs2_data[7:0]} << {memory_address[1:0], 3'b000};
        memory_write_mask = 4'b0001 << memory_address[1:0];
      end
      OP_SH: begin
        store_word        = {16'b0, rv32_rs2_data[15:0]} << {memory_address[1], 4'b0000};
        memory_write_mask = 4'b0011 << {memory_address[1], 1'b0};
      end
      OP_SW: begin
        store_word        = rv32_rs2_data;
        memory_write_mask = 4'b1111;
      end
      default: begin
        store_word        = '0;
        memory_write_mask = 4'b0000;
      end
    endcase
  end

  assign memory_write_data = MEMORY_WIDTH'(store_word);

  always_comb begin
    wb_enable   = 1'b0;
    wb_data     = '0;
    jump_taken  = 1'b0;
    jump_target = '0;
    case (op)
      OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_OR, OP_AND,
      OP_SRL, OP_SRA, OP_LUI, OP_AUIPC: begin
        wb_enable = 1'b1;
        wb_data   = alu_result;
      end
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
        jump_taken  = branch_taken;
        jump_target = pc_read_data + rv32_b_imm;
      end
      OP_JAL: begin
        wb_enable   = 1'b1;
        wb_data     = pc_read_data + 32'd4;
        jump_taken  = 1'b1;
        jump_target = pc_read_data + rv32_uj_imm;
      end
      OP_JALR: begin
        wb_enable   = 1'b1;
        wb_data     = pc_read_data + 32'd4;
        jump_taken  = 1'b1;
        jump_target = (rv32_rs1_data + rv32_i_imm) & ~32'd1;
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        wb_enable = 1'b1;
        wb_data   = load_result;
      end
      default: begin
        wb_enable   = 1'b0;
        wb_data     = '0;
        jump_taken  = 1'b0;
        jump_target = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_write_data   <= '0;
      rd_write_enable <= 1'b0;
      jump_enable     <= 1'b0;
      jump_address    <= '0;
    end else begin
      rd_write_data   <= wb_data;
      rd_write_enable <= wb_enable;
      jump_enable     <= jump_taken;
      jump_address    <= jump_taken ? jump_target : '0;
    end
  end

endmodule

// File: tb/tb_execute_unit.sv
// Directed self-checking bench for execute_unit: ALU, branches, jumps,
// loads/stores, no-op strobes, priority and asynchronous reset.
module tb_execute_unit;

  logic clk, rst_n;
  logic rv32_r_add, rv32_r_sub, rv32_r_sll, rv32_r_slt, rv32_r_sltu;
  logic rv32_r_xor, rv32_r_or, rv32_r_and, rv32_r_srl, rv32_r_sra;
  logic rv32_i_addi, rv32_i_slti, rv32_i_sltiu, rv32_i_xori, rv32_i_ori;
  logic rv32_i_andi, rv32_i_slli, rv32_i_srli, rv32_i_srai;
  logic rv32_b_beq, rv32_b_bne, rv32_b_blt, rv32_b_bge, rv32_b_bltu, rv32_b_bgeu;
  logic rv32_j_jal, rv32_i_jalr, rv32_u_lui, rv32_u_auipc;
  logic rv32_s_sb, rv32_s_sh, rv32_s_sw;
  logic rv32_i_lb, rv32_i_lh, rv32_i_lw, rv32_i_lbu, rv32_i_lhu;
  logic rv32_i_ecall, rv32_i_ebreak, rv32_i_csrrw, rv32_i_csrrs, rv32_i_csrrc;
  logic rv32_i_csrrwi, rv32_i_csrrsi, rv32_i_csrrci, rv32_i_fence, rv32_i_fence_i;
  logic rv32_r, rv32_i, rv32_s, rv32_u, rv32_j, rv32_b;
  logic [31:0] rv32_i_imm, rv32_s_imm, rv32_u_imm, rv32_uj_imm, rv32_b_imm;
  logic [31:0] rv32_rd_data, rv32_rs1_data, rv32_rs2_data, pc_read_data;
  logic [31:0] memory_read_data;
  logic [31:0] rd_write_data;
  logic        rd_write_enable, jump_enable;
  logic [31:0] jump_address, memory_address;
  logic        memory_read_enable, memory_write_enable;
  logic [31:0] memory_write_data;
  logic [3:0]  memory_write_mask;

  int checks = 0;
  int failures = 0;

  execute_unit #(.MEMORY_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .rv32_r_add(rv32_r_add), .rv32_r_sub(rv32_r_sub), .rv32_r_sll(rv32_r_sll),
    .rv32_r_slt(rv32_r_slt), .rv32_r_sltu(rv32_r_sltu), .rv32_r_xor(rv32_r_xor),
    .rv32_r_or(rv32_r_or), .rv32_r_and(rv32_r_and), .rv32_r_srl(rv32_r_srl),
    .rv32_r_sra(rv32_r_sra),
    .rv32_i_addi(rv32_i_addi), .rv32_i_slti(rv32_i_slti), .rv32_i_sltiu(rv32_i_sltiu),
    .rv32_i_xori(rv32_i_xori), .rv32_i_ori(rv32_i_ori), .rv32_i_andi(rv32_i_andi),
    .rv32_i_slli(rv32_i_slli), .rv32_i_srli(rv32_i_srli), .rv32_i_srai(rv32_i_srai),
    .rv32_b_beq(rv32_b_beq), .rv32_b_bne(rv32_b_bne), .rv32_b_blt(rv32_b_blt),
    .rv32_b_bge(rv32_b_bge), .rv32_b_bltu(rv32_b_bltu), .rv32_b_bgeu(rv32_b_bgeu),
    .rv32_j_jal(rv32_j_jal), .rv32_i_jalr(rv32_i_jalr), .rv32_u_lui(rv32_u_lui),
    .rv32_u_auipc(rv32_u_auipc),
    .rv32_s_sb(rv32_s_sb), .rv32_s_sh(rv32_s_sh), .rv32_s_sw(rv32_s_sw),
    .rv32_i_lb(rv32_i_lb), .rv32_i_lh(rv32_i_lh), .rv32_i_lw(rv32_i_lw),
    .rv32_i_lbu(rv32_i_lbu), .rv32_i_lhu(rv32_i_lhu),
    .rv32_i_ecall(rv32_i_ecall), .rv32_i_ebreak(rv32_i_ebreak),
    .rv32_i_csrrw(rv32_i_csrrw), .rv32_i_csrrs(rv32_i_csrrs), .rv32_i_csrrc(rv32_i_csrrc),
    .rv32_i_csrrwi(rv32_i_csrrwi), .rv32_i_csrrsi(rv32_i_csrrsi),
    .rv32_i_csrrci(rv32_i_csrrci), .rv32_i_fence(rv32_i_fence),
    .rv32_i_fence_i(rv32_i_fence_i),
    .rv32_r(rv32_r), .rv32_i(rv32_i), .rv32_s(rv32_s), .rv32_u(rv32_u),
    .rv32_j(rv32_j), .rv32_b(rv32_b),
    .rv32_i_imm(rv32_i_imm), .rv32_s_imm(rv32_s_imm), .rv32_u_imm(rv32_u_imm),
    .rv32_uj_imm(rv32_uj_imm), .rv32_b_imm(rv32_b_imm),
    .rv32_rd_data(rv32_rd_data), .rv32_rs1_data(rv32_rs1_data),
    .rv32_rs2_data(rv32_rs2_data), .pc_read_data(pc_read_data),
    .memory_read_data(memory_read_data),
    .rd_write_data(rd_write_data), .rd_write_enable(rd_write_enable),
    .jump_enable(jump_enable), .jump_address(jump_address),
    .memory_address(memory_address), .memory_read_enable(memory_read_enable),
    .memory_write_enable(memory_write_enable), .memory_write_data(memory_write_data),
    .memory_write_mask(memory_write_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Waits for a falling edge, then returns every decode input to idle.
  task automatic applyStimulus();
    @(negedge clk);
    {rv32_r_add, rv32_r_sub, rv32_r_sll, rv32_r_slt, rv32_r_sltu,
     rv32_r_xor, rv32_r_or, rv32_r_and, rv32_r_srl, rv32_r_sra} = '0;
    {rv32_i_addi, rv32_i_slti, rv32_i_sltiu, rv32_i_xori, rv32_i_ori,
     rv32_i_andi, rv32_i_slli, rv32_i_srli, rv32_i_srai} = '0;
    {rv32_b_beq, rv32_b_bne, rv32_b_blt, rv32_b_bge, rv32_b_bltu, rv32_b_bgeu} = '0;
    {rv32_j_jal, rv32_i_jalr, rv32_u_lui, rv32_u_auipc} = '0;
    {rv32_s_sb, rv32_s_sh, rv32_s_sw} = '0;
    {rv32_i_lb, rv32_i_lh, rv32_i_lw, rv32_i_lbu, rv32_i_lhu} = '0;
    {rv32_i_ecall, rv32_i_ebreak, rv32_i_csrrw, rv32_i_csrrs, rv32_i_csrrc,
     rv32_i_csrrwi, rv32_i_csrrsi, rv32_i_csrrci, rv32_i_fence, rv32_i_fence_i} = '0;
    {rv32_r, rv32_i, rv32_s, rv32_u, rv32_j, rv32_b} = '0;
    rv32_i_imm = '0; rv32_s_imm = '0; rv32_u_imm = '0; rv32_uj_imm = '0; rv32_b_imm = '0;
    rv32_rd_data = 32'h5A5A5A5A; rv32_rs1_data = '0; rv32_rs2_data = '0;
    pc_read_data = '0; memory_read_data = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus();
    #1;
    checkOutput("reset_rd_data", rd_write_data, 32'h0);
    checkOutput("reset_rd_we", {31'b0, rd_write_enable}, 32'h0);
    checkOutput("reset_jump_en", {31'b0, jump_enable}, 32'h0);
    checkOutput("reset_jump_addr", jump_address, 32'h0);
    checkOutput("nop_read_en", {31'b0, memory_read_enable}, 32'h0);
    checkOutput("nop_write_en", {31'b0, memory_write_enable}, 32'h0);
    rst_n = 1'b1;

    applyStimulus();
    rv32_r = 1; rv32_r_add = 1; rv32_rs1_data = 16; rv32_rs2_data = 16;
    tick();
    checkOutput("add_data", rd_write_data, 32'd32);
    checkOutput("add_we", {31'b0, rd_write_enable}, 32'h1);
    checkOutput("add_no_jump", {31'b0, jump_enable}, 32'h0);

    applyStimulus();
    rv32_i = 1; rv32_i_addi = 1; rv32_rs1_data = 16; rv32_i_imm = 32;
    tick();
    checkOutput("addi", rd_write_data, 32'd48);

    applyStimulus();
    rv32_i = 1; rv32_i_andi = 1; rv32_rs1_data = 16; rv32_i_imm = 32;
    tick();
    checkOutput("andi", rd_write_data, 32'd0);

    applyStimulus();
    rv32_i = 1; rv32_i_ori = 1; rv32_rs1_data = 16; rv32_i_imm = 32;
    tick();
    checkOutput("ori", rd_write_data, 32'd48);

    applyStimulus();
    rv32_r = 1; rv32_r_or = 1; rv32_rs1_data = 16; rv32_rs2_data = 16; rv32_i_imm = 32;
    tick();
    checkOutput("or_r", rd_write_data, 32'd16);

    applyStimulus();
    rv32_r = 1; rv32_r_sub = 1; rv32_rs1_data = 5; rv32_rs2_data = 7;
    tick();
    checkOutput("sub_wrap", rd_write_data, 32'hFFFFFFFE);

    applyStimulus();
    rv32_r = 1; rv32_r_slt = 1; rv32_rs1_data = 32'hFFFFFFFF; rv32_rs2_data = 1;
    tick();
    checkOutput("slt_signed", rd_write_data, 32'd1);

    applyStimulus();
    rv32_r = 1; rv32_r_sltu = 1; rv32_rs1_data = 32'hFFFFFFFF; rv32_rs2_data = 1;
    tick();
    checkOutput("sltu_unsigned", rd_write_data, 32'd0);

    applyStimulus();
    rv32_r = 1; rv32_r_xor = 1; rv32_rs1_data = 32'hF0F0F0F0; rv32_rs2_data = 32'hFF00FF00;
    tick();
    checkOutput("xor", rd_write_data, 32'h0FF00FF0);

    applyStimulus();
    rv32_i = 1; rv32_i_slli = 1; rv32_rs1_data = 1; rv32_i_imm = 31;
    tick();
    checkOutput("slli_31", rd_write_data, 32'h80000000);

    applyStimulus();
    rv32_i = 1; rv32_i_srli = 1; rv32_rs1_data = 32'h80000000; rv32_i_imm = 4;
    tick();
    checkOutput("srli", rd_write_data, 32'h08000000);

    applyStimulus();
    rv32_i = 1; rv32_i_srai = 1; rv32_rs1_data = 32'h80000000; rv32_i_imm = 32'h404;
    tick();
    checkOutput("srai", rd_write_data, 32'hF8000000);

    applyStimulus();
    rv32_u = 1; rv32_u_lui = 1; rv32_rs1_data = 32'h11111111; rv32_u_imm = 32'h12345000;
    tick();
    checkOutput("lui", rd_write_data, 32'h12345000);

    applyStimulus();
    rv32_u = 1; rv32_u_auipc = 1; pc_read_data = 32'h100; rv32_u_imm = 32'h12345000;
    rv32_rs1_data = 32'h11111111;
    tick();
    checkOutput("auipc", rd_write_data, 32'h12345100);

    applyStimulus();
    rv32_b = 1; rv32_b_beq = 1; rv32_rs1_data = 5; rv32_rs2_data = 5;
    pc_read_data = 32'h100; rv32_b_imm = 32'h20;
    tick();
    checkOutput("beq_taken", {31'b0, jump_enable}, 32'h1);
    checkOutput("beq_target", jump_address, 32'h120);
    checkOutput("beq_no_wb", {31'b0, rd_write_enable}, 32'h0);

    applyStimulus();
    rv32_b = 1; rv32_b_bne = 1; rv32_rs1_data = 5; rv32_rs2_data = 5;
    pc_read_data = 32'h100; rv32_b_imm = 32'h20;
    tick();
    checkOutput("bne_not_taken", {31'b0, jump_enable}, 32'h0);

    applyStimulus();
    rv32_b = 1; rv32_b_blt = 1; rv32_rs1_data = 32'hFFFFFFFF; rv32_rs2_data = 1;
    pc_read_data = 32'h100; rv32_b_imm = 32'hFFFFFFF0;
    tick();
    checkOutput("blt_taken", {31'b0, jump_enable}, 32'h1);
    checkOutput("blt_target", jump_address, 32'hF0);

    applyStimulus();
    rv32_b = 1; rv32_b_bltu = 1; rv32_rs1_data = 32'hFFFFFFFF; rv32_rs2_data = 1;
    pc_read_data = 32'h100; rv32_b_imm = 32'hFFFFFFF0;
    tick();
    checkOutput("bltu_not_taken", {31'b0, jump_enable}, 32'h0);

    applyStimulus();
    rv32_j = 1; rv32_j_jal = 1; pc_read_data = 32'h200; rv32_uj_imm = 32'h10;
    tick();
    checkOutput("jal_link", rd_write_data, 32'h204);
    checkOutput("jal_target", jump_address, 32'h210);
    checkOutput("jal_jump", {31'b0, jump_enable}, 32'h1);

    applyStimulus();
    rv32_i = 1; rv32_i_jalr = 1; rv32_rs1_data = 32'h1001; rv32_i_imm = 2;
    pc_read_data = 32'h40;
    tick();
    checkOutput("jalr_link", rd_write_data, 32'h44);
    checkOutput("jalr_target", jump_address, 32'h1002);
    checkOutput("jalr_we", {31'b0, rd_write_enable}, 32'h1);

    applyStimulus();
    rv32_s = 1; rv32_s_sb = 1; rv32_rs1_data = 32'h1003; rv32_s_imm = 0;
    rv32_rs2_data = 32'hAB; rv32_i_imm = 32'h40;
    #1;
    checkOutput("sb_addr", memory_address, 32'h1003);
    checkOutput("sb_mask", {28'b0, memory_write_mask}, 32'h8);
    checkOutput("sb_data", memory_write_data, 32'hAB000000);
    checkOutput("sb_write_en", {31'b0, memory_write_enable}, 32'h1);
    checkOutput("sb_read_en", {31'b0, memory_read_enable}, 32'h0);
    tick();
    checkOutput("sb_no_wb", {31'b0, rd_write_enable}, 32'h0);

    applyStimulus();
    rv32_s = 1; rv32_s_sh = 1; rv32_rs1_data = 32'h1000; rv32_s_imm = 3;
    rv32_rs2_data = 32'hFFFF1234;
    #1;
    checkOutput("sh_mask", {28'b0, memory_write_mask}, 32'hC);
    checkOutput("sh_data", memory_write_data, 32'h12340000);

    applyStimulus();
    rv32_s = 1; rv32_s_sw = 1; rv32_rs1_data = 32'h1000; rv32_s_imm = 1;
    rv32_rs2_data = 32'hDEADBEEF;
    #1;
    checkOutput("sw_mask", {28'b0, memory_write_mask}, 32'hF);
    checkOutput("sw_data", memory_write_data, 32'hDEADBEEF);

    applyStimulus();
    rv32_i = 1; rv32_i_lb = 1; rv32_rs1_data = 32'h1000; rv32_i_imm = 2;
    rv32_s_imm = 32'h80; memory_read_data = 32'h00800000;
    #1;
    checkOutput("lb_addr", memory_address, 32'h1002);
    checkOutput("lb_read_en", {31'b0, memory_read_enable}, 32'h1);
    checkOutput("lb_write_en", {31'b0, memory_write_enable}, 32'h0);
    tick();
    checkOutput("lb_sext", rd_write_data, 32'hFFFFFF80);
    checkOutput("lb_we", {31'b0, rd_write_enable}, 32'h1);

    applyStimulus();
    rv32_i = 1; rv32_i_lbu = 1; rv32_rs1_data = 32'h1002; memory_read_data = 32'h00800000;
    tick();
    checkOutput("lbu_zext", rd_write_data, 32'h00000080);

    applyStimulus();
    rv32_i = 1; rv32_i_lh = 1; rv32_rs1_data = 32'h1002; memory_read_data = 32'h80010000;
    tick();
    checkOutput("lh_sext", rd_write_data, 32'hFFFF8001);

    applyStimulus();
    rv32_i = 1; rv32_i_lhu = 1; rv32_rs1_data = 32'h1000; memory_read_data = 32'h1234F00D;
    tick();
    checkOutput("lhu_low", rd_write_data, 32'h0000F00D);

    applyStimulus();
    rv32_i = 1; rv32_i_lw = 1; rv32_rs1_data = 32'h1000; memory_read_data = 32'hCAFEF00D;
    tick();
    checkOutput("lw", rd_write_data, 32'hCAFEF00D);

    applyStimulus();
    rv32_i = 1; rv32_i_ecall = 1; rv32_rs1_data = 32'h1000; rv32_i_imm = 4;
    #1;
    checkOutput("ecall_read_en", {31'b0, memory_read_enable}, 32'h0);
    checkOutput("ecall_write_en", {31'b0, memory_write_enable}, 32'h0);
    tick();
    checkOutput("ecall_no_wb", {31'b0, rd_write_enable}, 32'h0);
    checkOutput("ecall_no_jump", {31'b0, jump_enable}, 32'h0);

    applyStimulus();
    rv32_r = 1; rv32_r_add = 1; rv32_r_sub = 1; rv32_rs1_data = 10; rv32_rs2_data = 3;
    tick();
    checkOutput("priority_add", rd_write_data, 32'd13);

    applyStimulus();
    rv32_j = 1; rv32_j_jal = 1; pc_read_data = 32'h300; rv32_uj_imm = 32'h8;
    tick();
    checkOutput("pre_reset_jump", {31'b0, jump_enable}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_rd_data", rd_write_data, 32'h0);
    checkOutput("async_rst_rd_we", {31'b0, rd_write_enable}, 32'h0);
    checkOutput("async_rst_jump_en", {31'b0, jump_enable}, 32'h0);
    checkOutput("async_rst_jump_addr", jump_address, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
